// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
//
// Clocked observer for a self-timed inverter/buffer oscillator ring. Every ring node goes through
// a two-flop synchronizer. The synchronized word is then decoded as a Johnson-style wavefront
// into a phase number 0..2N-1. The block checks that consecutive phases advance legally, locks
// after LOCK_CNT good samples, counts completed oscillation periods and latches faults.
//
// Ports:
//   clk          sampling clock
//   rst          asynchronous, active-high reset
//   ring_in      raw ring node values (asynchronous); bit 0 is the inverter output
//   clear        synchronous; clears fault, period count and lock, re-enters acquisition
//   phase        decoded phase 0..2N-1 (holds on an illegal sample and while faulted)
//   phase_valid  phase is a legal decode of the current sample
//   locked       monitor is in the run state
//   period_cnt   completed periods since lock, saturating
//   period_tick  one-cycle pulse per completed period
//   fault        sticky fault flag
//   fault_code   {skip, illegal}: 0 none, 1 illegal code, 2 skip/backward, 3 both
//
// While faulted, phase is frozen and phase_valid reads 0, because the held phase no longer
// describes the current sample.

module ring_phase_monitor #(
    parameter int unsigned N        = 10,
    parameter int unsigned MAX_STEP = 1,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned PW      = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     ring_in,
    input  logic             clear,
    output logic [PW-1:0]    phase,
    output logic             phase_valid,
    output logic             locked,
    output logic [CNT_W-1:0] period_cnt,
    output logic             period_tick,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int unsigned TwoN = 2 * N;

    typedef enum logic [1:0] {
        StAcquire,
        StRun,
        StFault
    } state_e;

    // Node pattern of phase p: a front of ones fills from bit 0, then a front of zeros follows it.
    function automatic logic [N-1:0] phase_pattern(input int unsigned p);
        logic [N-1:0] pat;
        for (int unsigned k = 0; k < N; k++) begin
            pat[k] = (p <= N) ? (k < p) : (k >= p - N);
        end
        return pat;
    endfunction

    logic [N-1:0]     sync1_q, s_q;
    state_e           state_q, state_d;
    logic [7:0]       lock_cnt_q, lock_cnt_d, lock_inc;
    logic             prev_valid_q, prev_valid_d;
    logic [PW-1:0]    p_prev_q, p_prev_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             period_tick_q, period_tick_d;
    logic [1:0]       fault_code_q, fault_code_d;

    logic             dec_legal;
    logic [PW-1:0]    dec_phase;
    logic [PW:0]      diff_raw, diff;
    logic             in_step, wrap;

    // Decode: at most one pattern can match, so the last-match-wins loop is unambiguous.
    always_comb begin
        dec_legal = 1'b0;
        dec_phase = '0;
        for (int unsigned p = 0; p < TwoN; p++) begin
            if (s_q == phase_pattern(p)) begin
                dec_legal = 1'b1;
                dec_phase = PW'(p);
            end
        end
    end

    // Forward distance modulo 2N from the previous legal phase.
    assign diff_raw = {1'b0, dec_phase} + (PW + 1)'(TwoN) - {1'b0, p_prev_q};
    assign diff     = (diff_raw >= (PW + 1)'(TwoN)) ? diff_raw - (PW + 1)'(TwoN) : diff_raw;
    assign in_step  = !prev_valid_q || (diff <= (PW + 1)'(MAX_STEP));
    // The path wraps through 2N-1 -> 0 when the unreduced landing point reaches 2N.
    assign wrap     = prev_valid_q && (({1'b0, p_prev_q} + diff) >= (PW + 1)'(TwoN));
    assign lock_inc = lock_cnt_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        lock_cnt_d    = lock_cnt_q;
        prev_valid_d  = prev_valid_q;
        p_prev_d      = p_prev_q;
        phase_d       = phase_q;
        phase_valid_d = 1'b0;
        period_cnt_d  = period_cnt_q;
        period_tick_d = 1'b0;
        fault_code_d  = fault_code_q;

        if (state_q != StFault || clear) begin
            phase_valid_d = dec_legal;
            if (dec_legal) begin
                phase_d = dec_phase;
            end
        end

        if (clear) begin
            state_d      = StAcquire;
            lock_cnt_d   = '0;
            prev_valid_d = 1'b0;
            period_cnt_d = '0;
            fault_code_d = 2'b00;
        end else begin
            if (dec_legal && state_q != StFault) begin
                prev_valid_d = 1'b1;
                p_prev_d     = dec_phase;
            end
            case (state_q)
                StAcquire: begin
                    if (dec_legal && in_step) begin
                        if (lock_inc == 8'(LOCK_CNT)) begin
                            state_d    = StRun;
                            lock_cnt_d = '0;
                        end else begin
                            lock_cnt_d = lock_inc;
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
                StRun: begin
                    if (!dec_legal || !in_step) begin
                        state_d      = StFault;
                        fault_code_d = {dec_legal & ~in_step, ~dec_legal};
                    end else if (wrap) begin
                        period_tick_d = 1'b1;
                        if (period_cnt_q != '1) begin
                            period_cnt_d = period_cnt_q + CNT_W'(1);
                        end
                    end
                end
                StFault: ;
                default: state_d = StAcquire;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '0;
            s_q           <= '0;
            state_q       <= StAcquire;
            lock_cnt_q    <= '0;
            prev_valid_q  <= 1'b0;
            p_prev_q      <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            period_cnt_q  <= '0;
            period_tick_q <= 1'b0;
            fault_code_q  <= 2'b00;
        end else begin
            sync1_q       <= ring_in;
            s_q           <= sync1_q;
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            prev_valid_q  <= prev_valid_d;
            p_prev_q      <= p_prev_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            period_cnt_q  <= period_cnt_d;
            period_tick_q <= period_tick_d;
            fault_code_q  <= fault_code_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign locked      = (state_q == StRun);
    assign fault       = (state_q == StFault);
    assign period_cnt  = period_cnt_q;
    assign period_tick = period_tick_q;
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor. Two instances share the ring stimulus: one with
// MAX_STEP=1 and one with MAX_STEP=2. CNT_W=2 keeps period-counter saturation reachable.
// A reference model steps once per clock on the value the DUT sees after synchronization,
// pushes the expected outputs into a queue, and a negedge monitor pops and compares.

module tb_ring_phase_monitor;

    localparam int N     = 10;
    localparam int PW    = 5;
    localparam int CW    = 2;
    localparam int LOCK  = 4;
    localparam int TWO_N = 2 * N;

    typedef struct packed {
        logic [PW-1:0] phase;
        logic          pv;
        logic          locked;
        logic [CW-1:0] pcnt;
        logic          tick;
        logic          fault;
        logic [1:0]    code;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [N-1:0]  ring_in = '0;

    logic [PW-1:0] phase_s [2];
    logic          pv_s    [2];
    logic          lk_s    [2];
    logic [CW-1:0] pcnt_s  [2];
    logic          tick_s  [2];
    logic          fault_s [2];
    logic [1:0]    code_s  [2];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int rp     = 0;
    bit primed = 1'b0;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [N-1:0] samp[$];

    // Reference model state, one slot per instance. st: 0 acquire, 1 run, 2 fault.
    int m_st[2], m_cnt[2], m_pp[2], m_pcnt[2], m_phase[2], m_code[2], m_max[2];
    bit m_prevv[2], m_pv[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ring_phase_monitor #(.N(N), .MAX_STEP(1), .LOCK_CNT(LOCK), .CNT_W(CW)) u_dut0 (
        .clk(clk), .rst(rst), .ring_in(ring_in), .clear(clear),
        .phase(phase_s[0]), .phase_valid(pv_s[0]), .locked(lk_s[0]), .period_cnt(pcnt_s[0]),
        .period_tick(tick_s[0]), .fault(fault_s[0]), .fault_code(code_s[0])
    );

    ring_phase_monitor #(.N(N), .MAX_STEP(2), .LOCK_CNT(LOCK), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst(rst), .ring_in(ring_in), .clear(clear),
        .phase(phase_s[1]), .phase_valid(pv_s[1]), .locked(lk_s[1]), .period_cnt(pcnt_s[1]),
        .period_tick(tick_s[1]), .fault(fault_s[1]), .fault_code(code_s[1])
    );

    // Ring word for phase p: p ones from the bottom, or all ones minus (p-N) low bits.
    function automatic logic [N-1:0] pattern(int p);
        if (p <= N) return N'((1 << p) - 1);
        return N'(((1 << N) - 1) - ((1 << (p - N)) - 1));
    endfunction

    function automatic int decode(logic [N-1:0] v);
        for (int p = 0; p < TWO_N; p++) begin
            if (pattern(p) == v) return p;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_pp[i] = 0; m_pcnt[i] = 0;
            m_phase[i] = 0; m_code[i] = 0; m_prevv[i] = 0; m_pv[i] = 0;
        end
        m_max[0] = 1;
        m_max[1] = 2;
    endfunction

    function automatic exp_t model_step(int i, logic [N-1:0] v, bit clr);
        int   pn;
        int   d;
        bit   instep;
        bit   wrap;
        bit   tick;
        exp_t e;
        pn   = decode(v);
        tick = 1'b0;
        if (m_st[i] != 2 || clr) begin
            m_pv[i] = (pn >= 0);
            if (pn >= 0) m_phase[i] = pn;
        end else begin
            m_pv[i] = 1'b0;
        end
        if (clr) begin
            m_st[i] = 0; m_cnt[i] = 0; m_prevv[i] = 0; m_pcnt[i] = 0; m_code[i] = 0;
        end else if (m_st[i] != 2) begin
            if (pn < 0) begin
                if (m_st[i] == 1) begin
                    m_st[i] = 2;
                    m_code[i] = 1;
                end else begin
                    m_cnt[i] = 0;
                end
            end else begin
                d      = (pn - m_pp[i] + TWO_N) % TWO_N;
                instep = !m_prevv[i] || (d <= m_max[i]);
                wrap   = m_prevv[i] && (m_pp[i] + d >= TWO_N);
                m_prevv[i] = 1'b1;
                m_pp[i]    = pn;
                if (m_st[i] == 0) begin
                    if (instep) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == LOCK) begin
                            m_st[i] = 1;
                            m_cnt[i] = 0;
                        end
                    end else begin
                        m_cnt[i] = 0;
                    end
                end else if (!instep) begin
                    m_st[i] = 2;
                    m_code[i] = 2;
                end else if (wrap) begin
                    tick = 1'b1;
                    if (m_pcnt[i] < (1 << CW) - 1) m_pcnt[i]++;
                end
            end
        end
        e.phase  = PW'(m_phase[i]);
        e.pv     = m_pv[i];
        e.locked = (m_st[i] == 1);
        e.pcnt   = CW'(m_pcnt[i]);
        e.tick   = tick;
        e.fault  = (m_st[i] == 2);
        e.code   = 2'(m_code[i]);
        return e;
    endfunction

    // Model process: the sample queue stands for the two-cycle synchronizer delay.
    initial begin
        logic [N-1:0] v;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
                samp.delete();
                samp.push_back('0);
                samp.push_back('0);
                q0.delete();
                q1.delete();
                primed = 1'b0;
            end else begin
                v = samp.pop_front();
                samp.push_back(ring_in);
                q0.push_back(model_step(0, v, clear));
                q1.push_back(model_step(1, v, clear));
                primed = 1'b1;
            end
        end
    end

    task automatic cmp(int i, exp_t e);
        exp_t g;
        g = {phase_s[i], pv_s[i], lk_s[i], pcnt_s[i], tick_s[i], fault_s[i], code_s[i]};
        n_vec++;
        if (g !== e) begin
            n_miss++;
            $display("FAIL dut%0d cycle %0d: got phase=%0d pv=%b lk=%b cnt=%0d tick=%b flt=%b code=%0d, expected phase=%0d pv=%b lk=%b cnt=%0d tick=%b flt=%b code=%0d",
                     i, cyc, g.phase, g.pv, g.locked, g.pcnt, g.tick, g.fault, g.code,
                     e.phase, e.pv, e.locked, e.pcnt, e.tick, e.fault, e.code);
        end
    endtask

    task automatic pop_cmp(int i);
        exp_t e;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_vec++;
            n_miss++;
            $display("FAIL dut%0d cycle %0d: scoreboard empty, no expected entry", i, cyc);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            cmp(i, e);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && primed) begin
                pop_cmp(0);
                pop_cmp(1);
            end
        end
    end

    task automatic chk_zero(string name);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({phase_s[i], pv_s[i], lk_s[i], pcnt_s[i], tick_s[i], fault_s[i], code_s[i]}
                !== 13'd0) begin
                n_miss++;
                $display("FAIL %s dut%0d: got phase=%0d pv=%b lk=%b cnt=%0d tick=%b flt=%b code=%0d, expected all 0",
                         name, i, phase_s[i], pv_s[i], lk_s[i], pcnt_s[i], tick_s[i],
                         fault_s[i], code_s[i]);
            end
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ev(int k, int gap);
        rp = (rp + k) % TWO_N;
        ring_in = pattern(rp);
        wait_cyc(gap);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
    endtask

    // Bits 3:0 = 0101 can never be a wavefront, whatever the upper bits hold.
    task automatic illegal(int gap);
        ring_in = N'(10'h005) ^ (N'(10'h3F0) & N'($urandom));
        wait_cyc(gap);
    endtask

    initial begin
        int r;
        #23;
        chk_zero("reset_state");
        wait_cyc(2);
        rst = 1'b0;

        // Clean walk, one event every 3 clocks, through a full period and beyond.
        for (int j = 0; j < 25; j++) ev(1, 3);
        for (int j = 0; j < 60; j++) ev(1, $urandom_range(1, 4));

        // Skip by 2 in run: faults the MAX_STEP=1 instance only.
        ev(2, 6);
        for (int j = 0; j < 5; j++) ev(1, 3);
        do_clear();
        for (int j = 0; j < 10; j++) ev(1, 2);

        // Illegal code in run, then legal patterns with the fault latched.
        illegal(3);
        ring_in = pattern(rp);
        wait_cyc(3);
        for (int j = 0; j < 5; j++) ev(1, 3);
        do_clear();
        for (int j = 0; j < 8; j++) ev(1, 3);

        // Backward step in run, then the same glitch during acquisition.
        ev(TWO_N - 1, 3);
        for (int j = 0; j < 3; j++) ev(1, 3);
        do_clear();
        ev(1, 1);
        ev(TWO_N - 1, 1);
        for (int j = 0; j < 10; j++) ev(1, 3);

        // Saturation of the 2-bit period counter, then clear mid-run and relock.
        for (int j = 0; j < 110; j++) ev(1, 2);
        do_clear();
        for (int j = 0; j < 30; j++) ev(1, 2);

        // Randomized mix of good steps, skips, backward steps, illegal codes and clears.
        for (int j = 0; j < 300; j++) begin
            r = $urandom_range(0, 19);
            if (r < 12) ev(1, $urandom_range(1, 4));
            else if (r < 14) ev(2, $urandom_range(1, 3));
            else if (r == 14) ev(TWO_N - 1, 2);
            else if (r == 15) begin
                illegal($urandom_range(1, 2));
                ring_in = pattern(rp);
                wait_cyc(2);
            end else if (r == 16) do_clear();
            else wait_cyc($urandom_range(1, 5));
            if (j % 25 == 24) do_clear();
        end

        // Asynchronous reset between edges while running.
        do_clear();
        for (int j = 0; j < 30; j++) ev(1, 2);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        wait_cyc(2);
        rp = 0;
        ring_in = '0;
        rst = 1'b0;
        wait_cyc(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
